tlb_ctrl: RTL and testbench

- Sequencer for the LoongArch TLB-maintenance instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits between the write-back stage / CSR file and the 16-entry TLB.
- Accepts one request at a time. Drives the TLB search-1 override, read, write and invalidate ports.
- Returns registered results for CSR.TLBIDX/TLBEHI/TLBELO/ASID update through a valid/ready response.

---
 rtl/tlb_pkg.sv | 99 +++++++++
 rtl/tlb_fill_cnt.sv | 25 ++
 rtl/tlb_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tlb_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types for the TLB-maintenance sequencer: packed entry layout,
// operation encodings and FSM state type.
package tlb_pkg;

   localparam int TLBE_W = 89;

   // Bit offsets of each field inside the packed entry, LSB first.
   localparam int V1_OFS   = 0;
   localparam int D1_OFS   = 1;
   localparam int MAT1_OFS = 2;
   localparam int PLV1_OFS = 4;
   localparam int PPN1_OFS = 6;
   localparam int V0_OFS   = 26;
   localparam int D0_OFS   = 27;
   localparam int MAT0_OFS = 28;
   localparam int PLV0_OFS = 30;
   localparam int PPN0_OFS = 32;
   localparam int G_OFS    = 52;
   localparam int ASID_OFS = 53;
   localparam int PS_OFS   = 63;
   localparam int VPPN_OFS = 69;
   localparam int E_OFS    = 88;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } tlbe_t;

   typedef enum logic [2:0] {
      TLBOP_SRCH = 3'd0,
      TLBOP_RD   = 3'd1,
      TLBOP_WR   = 3'd2,
      TLBOP_FILL = 3'd3,
      TLBOP_INV  = 3'd4
   } tlb_op_e;

   localparam logic [4:0] INV_OP_MAX = 5'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } tlb_state_e;

   function automatic tlbe_t to_tlbe(input logic [TLBE_W-1:0] v);
      tlbe_t t;
      t.e    = v[E_OFS];
      t.vppn = v[VPPN_OFS +: 19];
      t.ps   = v[PS_OFS +: 6];
      t.asid = v[ASID_OFS +: 10];
      t.g    = v[G_OFS];
      t.ppn0 = v[PPN0_OFS +: 20];
      t.plv0 = v[PLV0_OFS +: 2];
      t.mat0 = v[MAT0_OFS +: 2];
      t.d0   = v[D0_OFS];
      t.v0   = v[V0_OFS];
      t.ppn1 = v[PPN1_OFS +: 20];
      t.plv1 = v[PLV1_OFS +: 2];
      t.mat1 = v[MAT1_OFS +: 2];
      t.d1   = v[D1_OFS];
      t.v1   = v[V1_OFS];
      return t;
   endfunction

   function automatic logic [TLBE_W-1:0] from_tlbe(input tlbe_t t);
      logic [TLBE_W-1:0] v;
      v                   = '0;
      v[E_OFS]            = t.e;
      v[VPPN_OFS +: 19]   = t.vppn;
      v[PS_OFS +: 6]      = t.ps;
      v[ASID_OFS +: 10]   = t.asid;
      v[G_OFS]            = t.g;
      v[PPN0_OFS +: 20]   = t.ppn0;
      v[PLV0_OFS +: 2]    = t.plv0;
      v[MAT0_OFS +: 2]    = t.mat0;
      v[D0_OFS]           = t.d0;
      v[V0_OFS]           = t.v0;
      v[PPN1_OFS +: 20]   = t.ppn1;
      v[PLV1_OFS +: 2]    = t.plv1;
      v[MAT1_OFS +: 2]    = t.mat1;
      v[D1_OFS]           = t.d1;
      v[V1_OFS]           = t.v1;
      return v;
   endfunction

endpackage

// File: rtl/tlb_fill_cnt.sv
// TLBFILL replacement-index generator: round-robin over all entries.
// Kept separate so a different replacement policy can be dropped in.
module tlb_fill_cnt #(
   parameter int  TLBNUM    = 16,
   parameter int  FILL_SEED = 0,
   localparam int IDXW      = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            inc,
   output logic [IDXW-1:0] cnt
);

   localparam logic [IDXW-1:0] SEED = IDXW'(FILL_SEED);
   localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= SEED;
      end else if (inc) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/tlb_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between write-back/CSR
// and the TLB; one request in flight, registered response.
//
// state | meaning
// IDLE  | ready for a request, TLB ports quiet
// EXEC  | one cycle driving search/read/write/invalidate ports
// RESP  | result held until the consumer takes it
module tlb_ctrl
   import tlb_pkg::*;
#(
   parameter int  TLBNUM    = 16,
   parameter int  FILL_SEED = 0,
   localparam int IDXW      = $clog2(TLBNUM)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [4:0]        req_inv_op,
   input  logic [9:0]        req_inv_asid,
   input  logic [18:0]       req_inv_vppn,
   input  logic [TLBE_W-1:0] csr_entry,
   input  logic [IDXW-1:0]   csr_index,
   input  logic              csr_tlbr,
   output logic              s_sel,
   output logic [18:0]       s_vppn,
   output logic [9:0]        s_asid,
   input  logic              s_found,
   input  logic [IDXW-1:0]   s_index,
   output logic [IDXW-1:0]   r_index,
   input  logic [TLBE_W-1:0] r_entry,
   output logic              we,
   output logic [IDXW-1:0]   w_index,
   output logic [TLBE_W-1:0] w_entry,
   output logic              invtlb_valid,
   output logic [4:0]        invtlb_op,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_found,
   output logic [IDXW-1:0]   resp_index,
   output logic [TLBE_W-1:0] resp_entry,
   output logic              resp_err
);

   tlb_state_e      state;
   tlb_op_e         op_q;
   logic            err_q;
   tlb_op_e         dec_op;
   logic            dec_err;
   logic            fill_inc;
   logic [IDXW-1:0] fill_cnt;
   tlbe_t           csr_e;
   tlbe_t           wr_e;

   assign req_ready = (state == ST_IDLE);

   // Undefined opcodes behave as INVTLB but are flagged as errors.
   assign dec_op  = (req_op > 3'd4) ? TLBOP_INV : tlb_op_e'(req_op);
   assign dec_err = (req_op > 3'd4) ||
                    ((req_op == 3'd4) && (req_inv_op > INV_OP_MAX));

   assign csr_e = to_tlbe(csr_entry);

   // A refill handler always installs a valid entry; otherwise e carries ~NE.
   always_comb begin
      wr_e = csr_e;
      if (csr_tlbr) begin
         wr_e.e = 1'b1;
      end
   end

   assign fill_inc = (state == ST_EXEC) && (op_q == TLBOP_FILL);

   tlb_fill_cnt #(
      .TLBNUM    (TLBNUM),
      .FILL_SEED (FILL_SEED)
   ) u_fill_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (fill_inc),
      .cnt    (fill_cnt)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         op_q         <= TLBOP_SRCH;
         err_q        <= 1'b0;
         s_sel        <= 1'b0;
         s_vppn       <= '0;
         s_asid       <= '0;
         r_index      <= '0;
         we           <= 1'b0;
         w_index      <= '0;
         w_entry      <= '0;
         invtlb_valid <= 1'b0;
         invtlb_op    <= '0;
         resp_valid   <= 1'b0;
         resp_found   <= 1'b0;
         resp_index   <= '0;
         resp_entry   <= '0;
         resp_err     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state <= ST_EXEC;
                  op_q  <= dec_op;
                  err_q <= dec_err;
                  case (dec_op)
                     TLBOP_SRCH: begin
                        s_sel  <= 1'b1;
                        s_vppn <= csr_e.vppn;
                        s_asid <= csr_e.asid;
                     end
                     TLBOP_RD: begin
                        r_index <= csr_index;
                     end
                     TLBOP_WR: begin
                        we      <= 1'b1;
                        w_index <= csr_index;
                        w_entry <= from_tlbe(wr_e);
                     end
                     TLBOP_FILL: begin
                        we      <= 1'b1;
                        w_index <= fill_cnt;
                        w_entry <= from_tlbe(wr_e);
                     end
                     TLBOP_INV: begin
                        invtlb_valid <= 1'b1;
                        invtlb_op    <= req_inv_op;
                        s_sel        <= 1'b1;
                        s_vppn       <= req_inv_vppn;
                        s_asid       <= req_inv_asid;
                     end
                     default: ;
                  endcase
               end
            end
            ST_EXEC: begin
               state        <= ST_RESP;
               s_sel        <= 1'b0;
               we           <= 1'b0;
               invtlb_valid <= 1'b0;
               resp_valid   <= 1'b1;
               resp_err     <= err_q;
               resp_found   <= (op_q == TLBOP_SRCH) && s_found;
               resp_index   <= ((op_q == TLBOP_SRCH) && s_found) ? s_index : '0;
               // An invalid entry reads back as all zeros; NE is implied by e=0.
               resp_entry   <= ((op_q == TLBOP_RD) && r_entry[E_OFS]) ? r_entry : '0;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl with a small behavioural 16-entry TLB attached.
module tb_tlb_ctrl;
   import tlb_pkg::*;

   localparam int IDXW = 4;
   localparam int W    = TLBE_W;

   logic          clk = 1'b0;
   logic          resetn;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [4:0]    req_inv_op;
   logic [9:0]    req_inv_asid;
   logic [18:0]   req_inv_vppn;
   logic [W-1:0]  csr_entry;
   logic [IDXW-1:0] csr_index;
   logic          csr_tlbr;
   logic          s_sel;
   logic [18:0]   s_vppn;
   logic [9:0]    s_asid;
   logic          s_found;
   logic [IDXW-1:0] s_index;
   logic [IDXW-1:0] r_index;
   logic [W-1:0]  r_entry;
   logic          we;
   logic [IDXW-1:0] w_index;
   logic [W-1:0]  w_entry;
   logic          invtlb_valid;
   logic [4:0]    invtlb_op;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_found;
   logic [IDXW-1:0] resp_index;
   logic [W-1:0]  resp_entry;
   logic          resp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tlb_ctrl #(.TLBNUM(16), .FILL_SEED(0)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_inv_op   (req_inv_op),
      .req_inv_asid (req_inv_asid),
      .req_inv_vppn (req_inv_vppn),
      .csr_entry    (csr_entry),
      .csr_index    (csr_index),
      .csr_tlbr     (csr_tlbr),
      .s_sel        (s_sel),
      .s_vppn       (s_vppn),
      .s_asid       (s_asid),
      .s_found      (s_found),
      .s_index      (s_index),
      .r_index      (r_index),
      .r_entry      (r_entry),
      .we           (we),
      .w_index      (w_index),
      .w_entry      (w_entry),
      .invtlb_valid (invtlb_valid),
      .invtlb_op    (invtlb_op),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_found   (resp_found),
      .resp_index   (resp_index),
      .resp_entry   (resp_entry),
      .resp_err     (resp_err)
   );

   // Behavioural TLB: 16 entries, combinational search and read.
   tlbe_t tlb [16];

   function automatic logic inv_hit(input tlbe_t t, input logic [4:0] op,
                                    input logic [9:0] asid, input logic [18:0] vppn);
      logic am;
      logic vm;
      am = (t.asid == asid);
      vm = (t.vppn == vppn);
      case (op)
         5'd0, 5'd1: return 1'b1;
         5'd2:       return t.g;
         5'd3:       return !t.g;
         5'd4:       return !t.g && am;
         5'd5:       return !t.g && am && vm;
         5'd6:       return (t.g || am) && vm;
         default:    return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) tlb[i] <= '0;
      end else begin
         if (we) tlb[w_index] <= tlbe_t'(w_entry);
         if (invtlb_valid) begin
            for (int i = 0; i < 16; i++)
               if (inv_hit(tlb[i], invtlb_op, s_asid, s_vppn)) tlb[i].e <= 1'b0;
         end
      end
   end

   always_comb begin
      s_found = 1'b0;
      s_index = '0;
      for (int i = 15; i >= 0; i--) begin
         if (tlb[i].e && (tlb[i].vppn == s_vppn) && (tlb[i].g || (tlb[i].asid == s_asid))) begin
            s_found = 1'b1;
            s_index = IDXW'(i);
         end
      end
   end

   assign r_entry = tlb[r_index];

   function automatic tlbe_t mk(input logic e, input logic [18:0] vppn, input logic [9:0] asid,
                                input logic [19:0] ppn0, input logic [19:0] ppn1);
      tlbe_t t;
      t      = '0;
      t.e    = e;
      t.vppn = vppn;
      t.ps   = 6'd12;
      t.asid = asid;
      t.ppn0 = ppn0;
      t.mat0 = 2'd1;
      t.d0   = 1'b1;
      t.v0   = 1'b1;
      t.ppn1 = ppn1;
      t.mat1 = 2'd1;
      t.d1   = 1'b1;
      t.v1   = 1'b1;
      return t;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue a request from IDLE (called at posedge+1); returns at the EXEC-cycle negedge.
   task automatic send(input logic [2:0] op, input tlbe_t ent, input logic [3:0] idx,
                       input logic tlbr, input logic [4:0] iop = 5'd0,
                       input logic [9:0] iasid = 10'd0, input logic [18:0] ivppn = 19'd0);
      req_valid    = 1'b1;
      req_op       = op;
      csr_entry    = ent;
      csr_index    = idx;
      csr_tlbr     = tlbr;
      req_inv_op   = iop;
      req_inv_asid = iasid;
      req_inv_vppn = ivppn;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic to_resp();
      @(negedge clk);
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   tlbe_t e5, e7, e8, s_hit, s_miss, s_bp, f0, f1, none;

   initial begin
      e5     = mk(1'b1, 19'h12345, 10'h3, 20'h00055, 20'h00056);
      e7     = mk(1'b1, 19'h00777, 10'h1, 20'hABCDE, 20'h12121);
      e8     = mk(1'b0, 19'h00888, 10'h1, 20'h11111, 20'h22222);
      s_hit  = mk(1'b0, 19'h12345, 10'h3, 20'h0, 20'h0);
      s_miss = mk(1'b0, 19'h12345, 10'h4, 20'h0, 20'h0);
      s_bp   = mk(1'b0, 19'h00777, 10'h1, 20'h0, 20'h0);
      f0     = mk(1'b0, 19'h00ABC, 10'h2, 20'h00333, 20'h00444);
      f1     = mk(1'b1, 19'h00ABC, 10'h2, 20'h00333, 20'h00444);
      none   = '0;

      resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_inv_op = '0;
      req_inv_asid = '0; req_inv_vppn = '0; csr_entry = '0; csr_index = '0;
      csr_tlbr = 1'b0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("rst_req_ready", W'(req_ready), W'(1'b1));
      check("rst_resp_valid", W'(resp_valid), W'(1'b0));
      check("rst_s_sel", W'(s_sel), W'(1'b0));
      check("rst_we", W'(we), W'(1'b0));
      check("rst_invtlb_valid", W'(invtlb_valid), W'(1'b0));
      check("rst_resp_err", W'(resp_err), W'(1'b0));
      @(posedge clk); #1;

      // Preload through TLBWR (no refill context, e passes through).
      send(TLBOP_WR, e5, 4'd5, 1'b0);
      check("wr5_we", W'(we), W'(1'b1));
      check("wr5_w_index", W'(w_index), W'(4'd5));
      check("wr5_w_entry", w_entry, e5);
      to_resp();
      check("wr5_we_drop", W'(we), W'(1'b0));
      check("wr5_resp_valid", W'(resp_valid), W'(1'b1));
      ack();
      send(TLBOP_WR, e7, 4'd7, 1'b0);
      check("wr7_w_index", W'(w_index), W'(4'd7));
      to_resp(); ack();
      send(TLBOP_WR, e8, 4'd8, 1'b0);
      check("wr8_w_entry", w_entry, e8);
      to_resp(); ack();

      // SRCH hit on entry 5
      send(TLBOP_SRCH, s_hit, 4'd0, 1'b0);
      check("srch_s_sel", W'(s_sel), W'(1'b1));
      check("srch_s_vppn", W'(s_vppn), W'(19'h12345));
      check("srch_s_asid", W'(s_asid), W'(10'h3));
      check("srch_req_ready_busy", W'(req_ready), W'(1'b0));
      to_resp();
      check("srch_resp_valid", W'(resp_valid), W'(1'b1));
      check("srch_resp_found", W'(resp_found), W'(1'b1));
      check("srch_resp_index", W'(resp_index), W'(4'd5));
      check("srch_s_sel_drop", W'(s_sel), W'(1'b0));
      ack();
      check("srch_after_ack_valid", W'(resp_valid), W'(1'b0));
      check("srch_after_ack_ready", W'(req_ready), W'(1'b1));

      // SRCH with wrong ASID on non-global entry
      send(TLBOP_SRCH, s_miss, 4'd0, 1'b0);
      to_resp();
      check("miss_resp_found", W'(resp_found), W'(1'b0));
      check("miss_resp_index", W'(resp_index), W'(4'd0));
      ack();

      // RD valid entry 7, then invalid entry 8
      send(TLBOP_RD, none, 4'd7, 1'b0);
      check("rd7_r_index", W'(r_index), W'(4'd7));
      to_resp();
      check("rd7_ppn0", W'(resp_entry[PPN0_OFS +: 20]), W'(20'hABCDE));
      check("rd7_entry", resp_entry, e7);
      check("rd7_found", W'(resp_found), W'(1'b0));
      ack();
      send(TLBOP_RD, none, 4'd8, 1'b0);
      to_resp();
      check("rd8_entry_zero", resp_entry, W'(1'b0));
      ack();

      // INVTLB op 5 removes entry 5
      send(TLBOP_INV, none, 4'd0, 1'b0, 5'd5, 10'h3, 19'h12345);
      check("inv5_valid", W'(invtlb_valid), W'(1'b1));
      check("inv5_op", W'(invtlb_op), W'(5'd5));
      check("inv5_s_sel", W'(s_sel), W'(1'b1));
      check("inv5_s_vppn", W'(s_vppn), W'(19'h12345));
      check("inv5_s_asid", W'(s_asid), W'(10'h3));
      to_resp();
      check("inv5_valid_drop", W'(invtlb_valid), W'(1'b0));
      check("inv5_err", W'(resp_err), W'(1'b0));
      ack();
      send(TLBOP_SRCH, s_hit, 4'd0, 1'b0);
      to_resp();
      check("post_inv_found", W'(resp_found), W'(1'b0));
      ack();

      // INVTLB op 9: pulse issued, error flagged, TLB untouched
      send(TLBOP_INV, none, 4'd0, 1'b0, 5'd9, 10'h1, 19'h00777);
      check("inv9_valid", W'(invtlb_valid), W'(1'b1));
      check("inv9_op", W'(invtlb_op), W'(5'd9));
      to_resp();
      check("inv9_err", W'(resp_err), W'(1'b1));
      ack();
      send(TLBOP_RD, none, 4'd7, 1'b0);
      to_resp();
      check("inv9_rd7_kept", resp_entry, e7);
      check("rd_err_clear", W'(resp_err), W'(1'b0));
      ack();

      // Undefined opcode 7 behaves as INV with error
      send(3'd7, none, 4'd0, 1'b0, 5'd8, 10'h0, 19'h0);
      check("op7_inv_valid", W'(invtlb_valid), W'(1'b1));
      to_resp();
      check("op7_err", W'(resp_err), W'(1'b1));
      ack();

      // Backpressure: response held, new requests ignored
      send(TLBOP_SRCH, s_bp, 4'd0, 1'b0);
      to_resp();
      req_valid = 1'b1;
      req_op    = TLBOP_FILL;
      for (int k = 0; k < 5; k++) begin
         check("bp_resp_valid", W'(resp_valid), W'(1'b1));
         check("bp_resp_index", W'(resp_index), W'(4'd7));
         check("bp_resp_found", W'(resp_found), W'(1'b1));
         check("bp_req_ready", W'(req_ready), W'(1'b0));
         check("bp_we", W'(we), W'(1'b0));
         @(negedge clk);
      end
      req_valid = 1'b0;
      ack();

      // Four FILLs in refill context: indices 0..3, e forced to 1
      for (int k = 0; k < 4; k++) begin
         send(TLBOP_FILL, f0, 4'd9, 1'b1);
         check("fill_we", W'(we), W'(1'b1));
         check("fill_w_index", W'(w_index), W'(k));
         check("fill_w_e", W'(w_entry[E_OFS]), W'(1'b1));
         check("fill_w_entry", w_entry, f1);
         to_resp(); ack();
      end

      // WR outside refill keeps e=0 and does not advance the fill counter
      send(TLBOP_WR, f0, 4'd9, 1'b0);
      check("wr9_w_index", W'(w_index), W'(4'd9));
      check("wr9_w_entry", w_entry, f0);
      to_resp(); ack();

      // Sixteen more FILLs: 4..15 then wrap 0..3
      for (int k = 0; k < 16; k++) begin
         send(TLBOP_FILL, f0, 4'd9, 1'b1);
         check("fill_wrap_index", W'(w_index), W'((k + 4) % 16));
         to_resp(); ack();
      end

      // Reset while holding a response
      send(TLBOP_FILL, f0, 4'd9, 1'b1);
      check("fill_pre_rst_index", W'(w_index), W'(4'd4));
      to_resp();
      check("pre_rst_resp_valid", W'(resp_valid), W'(1'b1));
      resetn = 1'b0;
      @(posedge clk); #1;
      check("rst_resp_dropped", W'(resp_valid), W'(1'b0));
      check("rst_req_ready_back", W'(req_ready), W'(1'b1));
      check("rst_no_we", W'(we), W'(1'b0));
      resetn = 1'b1;
      @(posedge clk); #1;
      send(TLBOP_FILL, f0, 4'd9, 1'b1);
      check("fill_after_rst_index", W'(w_index), W'(4'd0));
      to_resp(); ack();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
